// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 target emulating a byte-serial SPI RAM.
// Supports READ (0x03) and WRITE (0x02) with a 24-bit address and unlimited
// streaming. SPI lines are oversampled on the system clock.
module spi_ram_responder #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_READ,
    S_WRITE,
    S_IGNORE
  } state_t;

  logic sck_m, sck_s, sck_d;
  logic cs_m, cs_s, cs_d;
  logic mosi_m, mosi_s;

  state_t            state;
  logic [4:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [ADDR_W-1:0] ptr;
  logic              is_read;
  logic              rd_first;

  logic [7:0] mem [DEPTH];

  logic              sck_rise, sck_fall, cs_fall;
  logic [7:0]        shift_in;
  logic [ADDR_W-1:0] ptr_inc;
  logic [7:0]        rd_cur, rd_next;
  logic              wr_en;

  // Two-flop synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_d  <= 1'b0;
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      cs_d   <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sck_m  <= sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      cs_m   <= cs_n;
      cs_s   <= cs_m;
      cs_d   <= cs_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign busy     = ~cs_s;

  assign shift_in = {shreg[6:0], mosi_s};
  assign ptr_inc  = ptr + 1'b1;
  assign rd_cur   = mem[ptr];
  assign rd_next  = mem[ptr_inc];
  // A byte is committed only on its 8th rise while still selected
  assign wr_en    = (state == S_WRITE) && !cs_s && sck_rise && (bit_cnt == 5'd7);

  // Transaction FSM: command/address decode, read shift-out, write pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      is_read  <= 1'b0;
      rd_first <= 1'b0;
      miso     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (cs_s && (state != S_IDLE)) begin
        state   <= S_IDLE;
        miso    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state   <= S_CMD;
              bit_cnt <= '0;
              miso    <= 1'b0;
            end
          end
          S_CMD: begin
            if (sck_rise) begin
              shreg <= shift_in;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (shift_in == 8'h03) begin
                  state   <= S_ADDR;
                  is_read <= 1'b1;
                end else if (shift_in == 8'h02) begin
                  state   <= S_ADDR;
                  is_read <= 1'b0;
                end else begin
                  state   <= S_IGNORE;
                  cmd_err <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              // Upper address bits shift out the top and are dropped
              ptr <= {ptr[ADDR_W-2:0], mosi_s};
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                rd_first <= 1'b1;
                state    <= is_read ? S_READ : S_WRITE;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_READ: begin
            // bit_cnt counts bits already presented in the current byte
            if (sck_fall) begin
              if (rd_first) begin
                rd_first <= 1'b0;
                miso     <= rd_cur[7];
                shreg    <= {rd_cur[6:0], 1'b0};
                bit_cnt  <= 5'd1;
              end else if (bit_cnt == 5'd8) begin
                ptr     <= ptr_inc;
                miso    <= rd_next[7];
                shreg   <= {rd_next[6:0], 1'b0};
                bit_cnt <= 5'd1;
              end else begin
                miso    <= shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_WRITE: begin
            if (sck_rise) begin
              shreg <= shift_in;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                ptr     <= ptr_inc;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_IGNORE: begin
            miso <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Backing store; deliberately not reset so contents survive resetn
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= shift_in;
    end
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb_spi_ram_responder: directed, table-driven bench for spi_ram_responder.
module tb_spi_ram_responder;

  logic clk, resetn, sck, cs_n, mosi;
  logic miso, busy, cmd_err;

  int n_cmp;
  int n_err;
  int err_hi;

  spi_ram_responder #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .sck     (sck),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clock cycles with cmd_err high
  initial err_hi = 0;
  always @(posedge clk) if (cmd_err === 1'b1) err_hi++;

  typedef struct packed {
    logic        is_rd;
    logic [23:0] addr;
    logic [2:0]  n;
    logic [31:0] data;   // bytes left-aligned, first byte in [31:24]
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One SPI bit, mode 0: miso sampled just before the rising edge
  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    #80;
    r = miso;
    sck = 1'b1;
    #80;
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #80;
    chk("busy_low_cs", {31'b0, busy}, 32'd1);
  endtask

  task automatic cs_end();
    #80;
    cs_n = 1'b1;
    #80;
    chk("busy_high_cs", {31'b0, busy}, 32'd0);
    #80;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    spi_byte(cmd, rx);
    chk("hdr_miso_cmd", {24'b0, rx}, 32'd0);
    spi_byte(addr[23:16], rx);
    chk("hdr_miso_a2", {24'b0, rx}, 32'd0);
    spi_byte(addr[15:8], rx);
    chk("hdr_miso_a1", {24'b0, rx}, 32'd0);
    spi_byte(addr[7:0], rx);
    chk("hdr_miso_a0", {24'b0, rx}, 32'd0);
  endtask

  task automatic txn(input vec_t v);
    logic [7:0] rx, b;
    cs_begin();
    send_hdr(v.is_rd ? 8'h03 : 8'h02, v.addr);
    for (int k = 0; k < int'(v.n); k++) begin
      b = v.data[31-8*k -: 8];
      if (v.is_rd) begin
        spi_byte(8'h00, rx);
        chk("read_byte", {24'b0, rx}, {24'b0, b});
      end else begin
        spi_byte(b, rx);
        chk("write_miso", {24'b0, rx}, 32'd0);
      end
    end
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;
    logic       r;
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    cs_n = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;

    tbl[0] = '{1'b0, 24'h000010, 3'd4, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 24'h000010, 3'd4, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 24'h0000FE, 3'd4, 32'h11223344};
    tbl[3] = '{1'b1, 24'h000000, 3'd2, 32'h33440000};
    tbl[4] = '{1'b1, 24'h0000FE, 3'd2, 32'h11220000};
    tbl[5] = '{1'b0, 24'h123405, 3'd1, 32'hA5000000};
    tbl[6] = '{1'b1, 24'h000005, 3'd1, 32'hA5000000};
    tbl[7] = '{1'b0, 24'h000020, 3'd2, 32'h775C0000};

    #42;
    chk("rst_miso", {31'b0, miso}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
    resetn = 1'b1;
    #100;

    for (int i = 0; i < 8; i++) txn(tbl[i]);

    // Unsupported command: ignored, one-cycle cmd_err, memory untouched
    chk("cmd_err_none_yet", err_hi, 0);
    cs_begin();
    send_hdr(8'h9F, 24'h000000);
    spi_byte(8'h55, rx);
    chk("bad_cmd_miso", {24'b0, rx}, 32'd0);
    cs_end();
    chk("cmd_err_one_clk", err_hi, 1);
    txn('{1'b1, 24'h000000, 3'd2, 32'h33440000});

    // Abort mid-byte: partial second byte must not land in memory
    cs_begin();
    send_hdr(8'h02, 24'h000020);
    spi_byte(8'hAA, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
    cs_end();
    txn('{1'b1, 24'h000020, 3'd2, 32'hAA5C0000});

    // Reset during the third streamed read byte
    cs_begin();
    send_hdr(8'h03, 24'h000010);
    spi_byte(8'h00, rx);
    chk("rstrd_b0", {24'b0, rx}, 32'hDE);
    spi_byte(8'h00, rx);
    chk("rstrd_b1", {24'b0, rx}, 32'hAD);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
    #80;
    chk("rstrd_miso_bit4", {31'b0, miso}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rstrd_miso_async", {31'b0, miso}, 32'd0);
    chk("rstrd_busy_async", {31'b0, busy}, 32'd0);
    #9;
    cs_n = 1'b1;
    #40;
    resetn = 1'b1;
    #100;
    txn('{1'b1, 24'h000010, 3'd4, 32'hDEADBEEF});
    chk("cmd_err_total", err_hi, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
